// File: rtl/conv_pkg.sv
// conv_pkg: shared definitions for the strided convolution engine.
//   - FSM state encoding
//   - memory operation codes driven on mem_operation
//   - descriptor word offsets relative to DESC_BASE
//   - CTRL word bit positions and shift field width
package conv_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_CHECK  = 4'd2,
    ST_OUTER  = 4'd3,
    ST_LOAD_A = 4'd4,
    ST_LOAD_F = 4'd5,
    ST_MAC    = 4'd6,
    ST_WRITE  = 4'd7,
    ST_DONE   = 4'd8
  } conv_state_e;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b11;

  localparam logic [2:0] DESC_WA   = 3'd0;
  localparam logic [2:0] DESC_HA   = 3'd1;
  localparam logic [2:0] DESC_WF   = 3'd2;
  localparam logic [2:0] DESC_HF   = 3'd3;
  localparam logic [2:0] DESC_S    = 3'd4;
  localparam logic [2:0] DESC_CTRL = 3'd5;
  localparam int         DESC_WORDS = 6;

  localparam int CTRL_SIGNED_BIT = 0;
  localparam int CTRL_SAT_BIT    = 1;
  localparam int CTRL_SHIFT_LSB  = 2;
  localparam int SHIFT_W         = 6;
  localparam int CTRL_W          = CTRL_SHIFT_LSB + SHIFT_W;

endpackage

// File: rtl/matrix_convolution_strided_if.sv
// matrix_convolution_strided_if: single-port word-addressed memory handshake.
//   mem_operation : 00 none, 01 read, 11 write (driven by the master)
//   addr_o/data_o : request address / write data (driven by the master)
//   mem_opdone    : transaction completes this cycle (driven by the memory)
//   data_i        : read data, valid with mem_opdone during a read
interface matrix_convolution_strided_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              mem_opdone;
  logic [DATA_W-1:0] data_i;
  logic [DATA_W-1:0] data_o;
  logic [ADDR_W-1:0] addr_o;
  logic [1:0]        mem_operation;

  modport master (
    input  mem_opdone, data_i,
    output data_o, addr_o, mem_operation
  );

  modport slave (
    output mem_opdone, data_i,
    input  data_o, addr_o, mem_operation
  );
endinterface

// File: rtl/conv_requant.sv
// conv_requant: combinational requantisation of the accumulator.
//   acc       : ACC_W accumulator value
//   shift     : right-shift amount (clamped to ACC_W-1)
//   is_signed : arithmetic shift and signed clamp when 1, logical/unsigned otherwise
//   saturate  : clamp to the DATA_W range when 1, plain truncation otherwise
//   result    : DATA_W output word
module conv_requant
  import conv_pkg::*;
#(
  parameter int ACC_W  = 64,
  parameter int DATA_W = 32
) (
  input  logic [ACC_W-1:0]   acc,
  input  logic [SHIFT_W-1:0] shift,
  input  logic               is_signed,
  input  logic               saturate,
  output logic [DATA_W-1:0]  result
);

  localparam logic [31:0]       MAX_SHIFT = 32'(ACC_W - 1);
  localparam logic [DATA_W-1:0] SMAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] UMAX = {DATA_W{1'b1}};

  logic [31:0]             shamt_s;
  logic signed [ACC_W-1:0] acc_sgn_s;
  logic [ACC_W-1:0]        shifted_s;
  logic                    sfit_s;

  // Shift, then either clamp or truncate to DATA_W.
  always_comb begin
    if ({{(32-SHIFT_W){1'b0}}, shift} > MAX_SHIFT) begin
      shamt_s = MAX_SHIFT;
    end else begin
      shamt_s = {{(32-SHIFT_W){1'b0}}, shift};
    end
    acc_sgn_s = acc;
    // Kept in separate branches so the arithmetic shift is not forced unsigned.
    if (is_signed) begin
      shifted_s = acc_sgn_s >>> shamt_s;
    end else begin
      shifted_s = acc >> shamt_s;
    end
    // Value fits a signed DATA_W word when all bits from DATA_W-1 upward agree.
    sfit_s = (&shifted_s[ACC_W-1:DATA_W-1]) || !(|shifted_s[ACC_W-1:DATA_W-1]);
    if (saturate && is_signed) begin
      if (sfit_s) begin
        result = shifted_s[DATA_W-1:0];
      end else begin
        result = shifted_s[ACC_W-1] ? SMIN : SMAX;
      end
    end else if (saturate) begin
      if (|shifted_s[ACC_W-1:DATA_W]) begin
        result = UMAX;
      end else begin
        result = shifted_s[DATA_W-1:0];
      end
    end else begin
      result = shifted_s[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/matrix_convolution_strided.sv
// matrix_convolution_strided: descriptor-driven valid-mode 2-D convolution with
// stride, signed/unsigned arithmetic, wide accumulation and requantisation.
//   clk, reset : clock (rising edge), asynchronous active-low reset
//   enable     : start request, sampled in IDLE and DONE only
//   mem        : memory handshake (master side), see matrix_convolution_strided_if
//   done       : job finished; error is valid while done=1
//   error      : descriptor rejected
//   busy       : engine working (every state except IDLE and DONE)
module matrix_convolution_strided
  import conv_pkg::*;
#(
  parameter int              DATA_W    = 32,
  parameter int              ADDR_W    = 32,
  parameter int              ACC_W     = 64,
  parameter logic [ADDR_W-1:0] DESC_BASE = {ADDR_W{1'b0}}
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  matrix_convolution_strided_if.master   mem,
  output logic                           done,
  output logic                           error,
  output logic                           busy
);

  localparam logic [DATA_W-1:0] ZERO_D = {DATA_W{1'b0}};
  localparam logic [DATA_W-1:0] ONE_D  = {{(DATA_W-1){1'b0}}, 1'b1};

  conv_state_e       state_r;
  logic [1:0]        mem_op_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic              done_r, error_r, busy_r;
  logic [2:0]        fetch_cnt_r;
  logic [DATA_W-1:0] wa_r, ha_r, wf_r, hf_r, s_r;
  logic [CTRL_W-1:0] ctrl_r;
  logic [DATA_W-1:0] oh_r, ow_r, i_r, j_r, k_r, l_r;
  logic [DATA_W-1:0] a_val_r, f_val_r;
  logic [ACC_W-1:0]  acc_r;

  logic              desc_bad_s;
  logic [DATA_W-1:0] div_s, oh_s, ow_s;
  logic [ADDR_W-1:0] a_base_s, f_base_s, r_base_s;
  logic [ADDR_W-1:0] a_addr_s, f_addr_s, r_addr_s;
  logic [2*DATA_W-1:0] a_ext_s, f_ext_s, prod_s;
  logic [ACC_W-1:0]  prod_ext_s;
  logic [DATA_W-1:0] requant_s;
  logic              sgn_s;

  assign sgn_s = ctrl_r[CTRL_SIGNED_BIT];

  // Descriptor validation, output dimensions and memory addresses.
  always_comb begin
    desc_bad_s = (wa_r == ZERO_D) || (ha_r == ZERO_D) || (wf_r == ZERO_D) ||
                 (hf_r == ZERO_D) || (s_r == ZERO_D) ||
                 (wf_r > wa_r) || (hf_r > ha_r);
    // Divisor forced non-zero; the quotient is only used when the descriptor is good.
    div_s    = (s_r == ZERO_D) ? ONE_D : s_r;
    oh_s     = (ha_r - hf_r) / div_s + ONE_D;
    ow_s     = (wa_r - wf_r) / div_s + ONE_D;
    a_base_s = DESC_BASE + ADDR_W'(DESC_WORDS);
    f_base_s = a_base_s + ADDR_W'(ha_r) * ADDR_W'(wa_r);
    r_base_s = f_base_s + ADDR_W'(hf_r) * ADDR_W'(wf_r);
    a_addr_s = a_base_s
             + (ADDR_W'(i_r) * ADDR_W'(s_r) + ADDR_W'(k_r)) * ADDR_W'(wa_r)
             + ADDR_W'(j_r) * ADDR_W'(s_r) + ADDR_W'(l_r);
    f_addr_s = f_base_s + ADDR_W'(k_r) * ADDR_W'(wf_r) + ADDR_W'(l_r);
    r_addr_s = r_base_s + ADDR_W'(i_r) * ADDR_W'(ow_r) + ADDR_W'(j_r);
  end

  // Operands extended to 2*DATA_W before multiplying: the low 2*DATA_W product
  // bits then equal the exact signed or unsigned product.
  assign a_ext_s = {{DATA_W{a_val_r[DATA_W-1] & sgn_s}}, a_val_r};
  assign f_ext_s = {{DATA_W{f_val_r[DATA_W-1] & sgn_s}}, f_val_r};
  assign prod_s  = a_ext_s * f_ext_s;

  if (ACC_W > 2*DATA_W) begin : g_prod_ext
    assign prod_ext_s = {{(ACC_W-2*DATA_W){prod_s[2*DATA_W-1] & sgn_s}}, prod_s};
  end else begin : g_prod_same
    assign prod_ext_s = prod_s;
  end

  conv_requant #(
    .ACC_W  (ACC_W),
    .DATA_W (DATA_W)
  ) u_requant (
    .acc       (acc_r),
    .shift     (ctrl_r[CTRL_SHIFT_LSB +: SHIFT_W]),
    .is_signed (ctrl_r[CTRL_SIGNED_BIT]),
    .saturate  (ctrl_r[CTRL_SAT_BIT]),
    .result    (requant_s)
  );

  assign mem.mem_operation = mem_op_r;
  assign mem.addr_o        = addr_r;
  assign mem.data_o        = wdata_r;
  assign done              = done_r;
  assign error             = error_r;
  assign busy              = busy_r;

  // Control FSM, memory request registers and datapath state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      mem_op_r    <= MEM_NONE;
      addr_r      <= {ADDR_W{1'b0}};
      wdata_r     <= ZERO_D;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
      busy_r      <= 1'b0;
      fetch_cnt_r <= 3'd0;
      wa_r        <= ZERO_D;
      ha_r        <= ZERO_D;
      wf_r        <= ZERO_D;
      hf_r        <= ZERO_D;
      s_r         <= ZERO_D;
      ctrl_r      <= {CTRL_W{1'b0}};
      oh_r        <= ZERO_D;
      ow_r        <= ZERO_D;
      i_r         <= ZERO_D;
      j_r         <= ZERO_D;
      k_r         <= ZERO_D;
      l_r         <= ZERO_D;
      a_val_r     <= ZERO_D;
      f_val_r     <= ZERO_D;
      acc_r       <= {ACC_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r  <= 1'b0;
          error_r <= 1'b0;
          if (enable) begin
            state_r     <= ST_FETCH;
            busy_r      <= 1'b1;
            fetch_cnt_r <= 3'd0;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        // Request issued from an idle bus, so a 00 cycle always precedes it.
        ST_FETCH: begin
          if (mem_op_r == MEM_NONE) begin
            mem_op_r <= MEM_READ;
            addr_r   <= DESC_BASE + ADDR_W'(fetch_cnt_r);
          end else if (mem.mem_opdone) begin
            mem_op_r <= MEM_NONE;
            case (fetch_cnt_r)
              DESC_WA:   wa_r   <= mem.data_i;
              DESC_HA:   ha_r   <= mem.data_i;
              DESC_WF:   wf_r   <= mem.data_i;
              DESC_HF:   hf_r   <= mem.data_i;
              DESC_S:    s_r    <= mem.data_i;
              DESC_CTRL: ctrl_r <= mem.data_i[CTRL_W-1:0];
              default:   ctrl_r <= ctrl_r;
            endcase
            if (fetch_cnt_r == DESC_CTRL) begin
              state_r <= ST_CHECK;
            end else begin
              fetch_cnt_r <= fetch_cnt_r + 3'd1;
            end
          end else begin
            mem_op_r <= mem_op_r;
          end
        end
        ST_CHECK: begin
          if (desc_bad_s) begin
            error_r <= 1'b1;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= ST_DONE;
          end else begin
            oh_r    <= oh_s;
            ow_r    <= ow_s;
            i_r     <= ZERO_D;
            j_r     <= ZERO_D;
            state_r <= ST_OUTER;
          end
        end
        ST_OUTER: begin
          if (i_r == oh_r) begin
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= ST_DONE;
          end else begin
            k_r     <= ZERO_D;
            l_r     <= ZERO_D;
            acc_r   <= {ACC_W{1'b0}};
            state_r <= ST_LOAD_A;
          end
        end
        ST_LOAD_A: begin
          if (mem_op_r == MEM_NONE) begin
            mem_op_r <= MEM_READ;
            addr_r   <= a_addr_s;
          end else if (mem.mem_opdone) begin
            mem_op_r <= MEM_NONE;
            a_val_r  <= mem.data_i;
            state_r  <= ST_LOAD_F;
          end else begin
            mem_op_r <= mem_op_r;
          end
        end
        ST_LOAD_F: begin
          if (mem_op_r == MEM_NONE) begin
            mem_op_r <= MEM_READ;
            addr_r   <= f_addr_s;
          end else if (mem.mem_opdone) begin
            mem_op_r <= MEM_NONE;
            f_val_r  <= mem.data_i;
            state_r  <= ST_MAC;
          end else begin
            mem_op_r <= mem_op_r;
          end
        end
        // l runs fastest and wraps into k; the last (k,l) pair goes to WRITE.
        ST_MAC: begin
          acc_r <= acc_r + prod_ext_s;
          if (l_r == wf_r - ONE_D) begin
            l_r <= ZERO_D;
            if (k_r == hf_r - ONE_D) begin
              k_r     <= ZERO_D;
              state_r <= ST_WRITE;
            end else begin
              k_r     <= k_r + ONE_D;
              state_r <= ST_LOAD_A;
            end
          end else begin
            l_r     <= l_r + ONE_D;
            state_r <= ST_LOAD_A;
          end
        end
        ST_WRITE: begin
          if (mem_op_r == MEM_NONE) begin
            mem_op_r <= MEM_WRITE;
            addr_r   <= r_addr_s;
            wdata_r  <= requant_s;
          end else if (mem.mem_opdone) begin
            mem_op_r <= MEM_NONE;
            state_r  <= ST_OUTER;
            if (j_r == ow_r - ONE_D) begin
              j_r <= ZERO_D;
              i_r <= i_r + ONE_D;
            end else begin
              j_r <= j_r + ONE_D;
            end
          end else begin
            mem_op_r <= mem_op_r;
          end
        end
        ST_DONE: begin
          if (!enable) begin
            done_r  <= 1'b0;
            error_r <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_DONE;
          end
        end
        default: begin
          mem_op_r <= MEM_NONE;
          done_r   <= 1'b0;
          error_r  <= 1'b0;
          busy_r   <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_convolution_strided.sv
// tb_matrix_convolution_strided: directed bench for matrix_convolution_strided.
// A word-array memory model answers requests after a programmable latency and
// logs every write; results are compared against hand-computed tables.
module tb_matrix_convolution_strided;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int ACC_W  = 64;
  localparam int BUDGET = 3000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic done, error, busy;

  matrix_convolution_strided_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  matrix_convolution_strided #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .ACC_W     (ACC_W),
    .DESC_BASE (32'd0)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .mem    (bus.master),
    .done   (done),
    .error  (error),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  logic [31:0] mem_a [0:127];
  int          lat = 0;
  int          wait_n = 0;
  int          rd_cnt = 0;
  int          checks_n = 0;
  int          errors_n = 0;
  bit          stall_chk = 1'b0;
  logic [31:0] hold_addr, hold_data;
  logic [1:0]  hold_op;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [31:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_n++;
    if (got !== exp) begin
      errors_n++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Memory model: answers each request after lat waiting cycles.
  always @(negedge clk) begin
    if (!reset) begin
      bus.mem_opdone = 1'b0;
      bus.data_i     = 32'd0;
      wait_n         = 0;
    end else if (bus.mem_opdone) begin
      bus.mem_opdone = 1'b0;
      wait_n         = 0;
    end else if (bus.mem_operation != 2'b00) begin
      if (wait_n == 0) begin
        hold_addr = bus.addr_o;
        hold_data = bus.data_o;
        hold_op   = bus.mem_operation;
      end
      if (wait_n >= lat) begin
        if (stall_chk) begin
          check_val("hold_addr", bus.addr_o, hold_addr);
          check_val("hold_data", bus.data_o, hold_data);
          check_val("hold_op", 32'(bus.mem_operation), 32'(hold_op));
        end
        bus.mem_opdone = 1'b1;
        if (bus.mem_operation == 2'b01) begin
          bus.data_i = mem_a[bus.addr_o[6:0]];
          rd_cnt++;
        end else begin
          mem_a[bus.addr_o[6:0]] = bus.data_o;
          wr_addr_q.push_back(bus.addr_o);
          wr_data_q.push_back(bus.data_o);
        end
      end else begin
        wait_n++;
      end
    end else begin
      bus.mem_opdone = 1'b0;
    end
  end

  task automatic clear_mem();
    for (int a = 0; a < 128; a++) mem_a[a] = 32'd0;
  endtask

  task automatic set_desc(input int wa, input int ha, input int wf, input int hf,
                          input int s, input int ctrl);
    clear_mem();
    mem_a[0] = 32'(wa);
    mem_a[1] = 32'(ha);
    mem_a[2] = 32'(wf);
    mem_a[3] = 32'(hf);
    mem_a[4] = 32'(s);
    mem_a[5] = 32'(ctrl);
  endtask

  task automatic load_basic();
    set_desc(3, 3, 2, 2, 1, 0);
    for (int a = 0; a < 9; a++) mem_a[6 + a] = 32'(a + 1);
    mem_a[15] = 32'd1;
    mem_a[16] = 32'd0;
    mem_a[17] = 32'd0;
    mem_a[18] = 32'd1;
    exp_q = {32'd6, 32'd8, 32'd12, 32'd14};
  endtask

  // Start a job, wait for done, check done/error behaviour, release enable.
  task automatic run_job(input string tag, input logic exp_err);
    int n;
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_cnt = 0;
    @(negedge clk);
    enable = 1'b1;
    n = 0;
    while (!done && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_timeout"}, 32'(n < BUDGET), 32'd1);
    check_val({tag, "_error"}, 32'(error), 32'(exp_err));
    repeat (3) @(negedge clk);
    check_val({tag, "_done_held"}, 32'(done), 32'd1);
    check_val({tag, "_busy_done"}, 32'(busy), 32'd0);
    enable = 1'b0;
    @(negedge clk);
    check_val({tag, "_done_clr"}, 32'({done, error}), 32'd0);
  endtask

  task automatic check_writes(input string tag, input logic [31:0] base);
    check_val({tag, "_wr_count"}, 32'(wr_addr_q.size()), 32'(exp_q.size()));
    for (int w = 0; w < exp_q.size(); w++) begin
      if (w < wr_addr_q.size()) begin
        check_val({tag, "_wr_addr"}, wr_addr_q[w], base + 32'(w));
        check_val({tag, "_wr_data"}, wr_data_q[w], exp_q[w]);
      end
    end
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_outputs", 32'({done, error, busy, bus.mem_operation}), 32'd0);
    check_val("rst_addr", bus.addr_o, 32'd0);
    check_val("rst_data", bus.data_o, 32'd0);
    reset = 1'b1;

    // Basic 3x3 with 2x2 diagonal filter.
    load_basic();
    run_job("basic", 1'b0);
    check_writes("basic", 32'd19);

    // Stride 2 over 5x5 with 1x1 unit filter.
    set_desc(5, 5, 1, 1, 2, 0);
    for (int a = 0; a < 25; a++) mem_a[6 + a] = 32'(a);
    mem_a[31] = 32'd1;
    exp_q = {32'd0, 32'd2, 32'd4, 32'd10, 32'd12, 32'd14, 32'd20, 32'd22, 32'd24};
    run_job("stride", 1'b0);
    check_writes("stride", 32'd32);

    // Signed product -12, arithmetic shift by 1.
    set_desc(1, 1, 1, 1, 1, 5);
    mem_a[6] = 32'hFFFF_FFFC;
    mem_a[7] = 32'd3;
    exp_q = {32'hFFFF_FFFA};
    run_job("sshift", 1'b0);
    check_writes("sshift", 32'd8);

    // Signed saturation of 0xFFFFFFFE (positive) to INT_MAX.
    set_desc(1, 1, 1, 1, 1, 3);
    mem_a[6] = 32'h7FFF_FFFF;
    mem_a[7] = 32'd2;
    exp_q = {32'h7FFF_FFFF};
    run_job("sat", 1'b0);
    check_writes("sat", 32'd8);

    // Same product without saturation: plain truncation.
    set_desc(1, 1, 1, 1, 1, 1);
    mem_a[6] = 32'h7FFF_FFFF;
    mem_a[7] = 32'd2;
    exp_q = {32'hFFFF_FFFE};
    run_job("nosat", 1'b0);
    check_writes("nosat", 32'd8);

    // Filter taller than the matrix.
    set_desc(3, 3, 3, 4, 1, 0);
    run_job("bad_hf", 1'b1);
    check_val("bad_hf_reads", 32'(rd_cnt), 32'd6);
    check_val("bad_hf_writes", 32'(wr_addr_q.size()), 32'd0);

    // Zero stride.
    set_desc(3, 3, 2, 2, 0, 0);
    run_job("bad_s", 1'b1);
    check_val("bad_s_reads", 32'(rd_cnt), 32'd6);
    check_val("bad_s_writes", 32'(wr_addr_q.size()), 32'd0);

    // Five-cycle memory latency: requests must stay stable while stalled.
    load_basic();
    lat = 5;
    stall_chk = 1'b1;
    run_job("stall", 1'b0);
    check_writes("stall", 32'd19);
    stall_chk = 1'b0;

    // Reset while the first A read is pending.
    load_basic();
    @(negedge clk);
    enable = 1'b1;
    n = 0;
    while (!(bus.mem_operation == 2'b01 && bus.addr_o == 32'd6) && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check_val("mid_reset_reach", 32'(n < BUDGET), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_val("mid_reset_outs", 32'({done, error, busy, bus.mem_operation}), 32'd0);
    check_val("mid_reset_addr", bus.addr_o, 32'd0);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b1;
    lat = 0;
    check_val("mid_reset_idle", 32'({done, busy}), 32'd0);

    // Clean rerun after reset.
    run_job("rerun", 1'b0);
    check_writes("rerun", 32'd19);

    $display("Simulation finished: %0d checks, %0d errors", checks_n, errors_n);
    $finish;
  end

endmodule
